// File: rtl/universal_shift_reg.sv
// Universal WIDTH-bit shift register.
// Modes: hold, shift right, shift left and parallel load.
// Serial taps sit at both ends of the register.
// A shift counter raises a one-cycle frame_done pulse after every WIDTH-th shift.
module universal_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic                     serial_in_msb,
   input  logic                     serial_in_lsb,
   input  logic [WIDTH-1:0]         parallel_in,
   output logic [WIDTH-1:0]         parallel_out,
   output logic                     serial_out_lsb,
   output logic                     serial_out_msb,
   output logic [$clog2(WIDTH)-1:0] shift_count,
   output logic                     frame_done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_q, frame_d;
   logic             shift_s;

   // Next-state logic: mode decode, data movement and frame counting.
   always_comb begin
      data_d  = data_q;
      cnt_d   = cnt_q;
      frame_d = 1'b0;
      shift_s = 1'b0;
      if (enable) begin
         case (mode)
            MODE_HOLD: begin
               data_d = data_q;
            end
            MODE_RIGHT: begin
               data_d  = {serial_in_msb, data_q[WIDTH-1:1]};
               shift_s = 1'b1;
            end
            MODE_LEFT: begin
               data_d  = {data_q[WIDTH-2:0], serial_in_lsb};
               shift_s = 1'b1;
            end
            MODE_LOAD: begin
               data_d = parallel_in;
               cnt_d  = {CNT_W{1'b0}};
            end
            default: begin
               data_d = data_q;
            end
         endcase
      end else begin
         data_d = data_q;
      end

      // Either shift direction advances the same frame.
      // The WIDTH-th shift wraps the count and flags the frame.
      if (shift_s) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d   = {CNT_W{1'b0}};
            frame_d = 1'b1;
         end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         frame_d = 1'b0;
      end
   end

   // State registers with synchronous reset taking priority over enable and mode.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         frame_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         frame_q <= frame_d;
      end
   end

   assign parallel_out   = data_q;
   assign serial_out_lsb = data_q[0];
   assign serial_out_msb = data_q[WIDTH-1];
   assign shift_count    = cnt_q;
   assign frame_done     = frame_q;

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised successor to the team's fixed 4-bit serial-in/serial-out shifter. It provides WIDTH-bit storage with four modes: hold, shift right, shift left and parallel load. It has serial ports at both ends, a clock enable, and a shift counter that flags each completed WIDTH-bit frame. It is the common building block for serialisers, deserialisers and bit-reversal paths in the datapath.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH), width of shift_count (derived localparam, not user-overridable).

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  clock enable; when low, all state holds regardless of mode.
mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
serial_in_msb  input  1  bit entering at bit WIDTH-1 on shift right.
serial_in_lsb  input  1  bit entering at bit 0 on shift left.
parallel_in  input  WIDTH  load data for mode 11.
parallel_out  output  WIDTH  current register contents q.
serial_out_lsb  output  1  q[0]; the serial output for shift right.
serial_out_msb  output  1  q[WIDTH-1]; the serial output for shift left.
shift_count  output  CNT_W  shifts performed since the last load, reset or frame wrap.
frame_done  output  1  one-cycle pulse after the WIDTH-th shift of a frame.

Behaviour:
- Reset (synchronous, active-high):
  - Priority over enable and mode.
  - Next edge: q=0, shift_count=0, frame_done=0.
  - All outputs therefore read 0 the cycle after reset is sampled high.
  - Reset mid-frame discards the partial frame and the count.
- Enable:
  - When enable=0: q, shift_count hold; frame_done registers 0.
- Mode actions, when enable=1, on the rising edge:
  - 00 hold: q unchanged, count unchanged, frame_done<=0.
  - 01 shift right: q <= {serial_in_msb, q[WIDTH-1:1]}.
  - 10 shift left: q <= {q[WIDTH-2:0], serial_in_lsb}.
  - 11 load: q <= parallel_in, shift_count<=0, frame_done<=0.
- Shift counter:
  - Increments on every shift, whichever direction.
  - A direction change mid-frame does not reset the count.
  - When a shift occurs with shift_count==WIDTH-1: count wraps to 0 and frame_done<=1 on the same edge.
  - frame_done is high for exactly one cycle, unless the next cycle also completes a frame (impossible for WIDTH>=2).
- Latency:
  - Data and serial outputs: 1 cycle from the sampling edge.
  - serial_out_* are combinational taps of q (no extra register).
  - frame_done is registered and is visible in the same cycle the final shifted value appears on parallel_out.
- Simultaneous events:
  - Load during what would be the final shift cannot occur (mode is exclusive).
  - A load on the cycle after frame_done is legal and needs no dead cycle.
- Outputs are glitch-free registered values except the two serial taps, which are direct wires from registers.
- No X propagation from parallel_in unless mode=11.

Test Plan:
- Reset: WIDTH=4, drive q nonzero, assert reset with enable=0 -> next cycle parallel_out=0, shift_count=0, frame_done=0.
- Right-shift frame: WIDTH=4, mode=01, serial_in_msb=1,0,1,1 over 4 edges.
  - parallel_out after each edge: 1000, 0100, 1010, 1101.
  - serial_out_lsb=1 at the end.
  - frame_done=1 for one cycle after edge 4; shift_count 1,2,3,0.
- Load then left shift: WIDTH=8, load 0xA5, then mode=10 with serial_in_lsb=0 -> 0x4A, serial_out_msb=0, shift_count=1.
- Load then right shift: WIDTH=8, load 0xA5, then mode=01 with serial_in_msb=1 -> 0xD2, serial_out_lsb=0.
- Enable/hold: mid-frame with shift_count=2, deassert enable for 3 cycles, then use mode=00 for 2 cycles.
  - q and count stay frozen; frame_done stays 0.
  - Resuming shifts completes the frame after exactly WIDTH-2 further shifts.
- Mid-frame interruptions: at shift_count=3 (WIDTH=8), assert reset -> count=0, q=0, no frame_done. Repeat with a load instead of reset -> count=0, q=parallel_in.
- Direction change: WIDTH=4, two right shifts then two left shifts -> frame_done pulses after the 4th shift.
